// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO family.
//   FIFO_WIDTH     : default data width, shared by FIFO blocks and their readers
//   FIFO_BUF_DEPTH : default prefetch buffer depth
//   ptr_w(depth)   : index width needed to address `depth` entries (min 1 bit)
package fifo_pkg;

    localparam int FIFO_WIDTH     = 8;
    localparam int FIFO_BUF_DEPTH = 4;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fifo_prefetch_buf.sv
// Circular prefetch storage with push/pop and occupancy count.
//   clk, reset_n : clock, asynchronous active-low reset
//   push         : write push_data at the write index this cycle
//   push_data    : data to store
//   pop          : release the entry at the read index this cycle (caller keeps it legal)
//   pop_data     : entry at the read index (head of the buffer)
//   occ          : number of stored entries, 0..DEPTH
// DEPTH must be a power of two so the indices wrap by natural overflow.
module fifo_prefetch_buf
    import fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH,
    parameter int DEPTH = FIFO_BUF_DEPTH,
    localparam int OCC_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [OCC_W-1:0] occ
);

    localparam int PW = ptr_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_idx;
    logic [PW-1:0]    rd_idx;

    // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_idx <= '0;
            rd_idx <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_idx <= wr_idx + 1'b1;
            if (pop)  rd_idx <= rd_idx + 1'b1;
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: ;
            endcase
        end
    end

    // NOTE: storage is not reset; entries are only read once occ says they were written.
    always_ff @(posedge clk) begin
        if (push) mem[wr_idx] <= push_data;
    end

    assign pop_data = mem[rd_idx];

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side controller: pulls words from a FIFO read port (1-cycle read latency)
// and presents them as a valid/ready stream grouped into PKT_LEN-beat packets.
//   clk, reset_n : clock, asynchronous active-low reset
//   enable       : allow new FIFO reads
//   fifo_empty   : FIFO empty flag
//   fifo_rd_en   : FIFO read request (every request is accepted)
//   fifo_dout    : FIFO data, valid the cycle after an accepted read
//   m_valid/m_ready/m_data/m_last : output stream, m_last on beat PKT_LEN-1
//   level        : prefetch buffer occupancy (excludes the in-flight word)
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int WIDTH     = FIFO_WIDTH,
    parameter int BUF_DEPTH = FIFO_BUF_DEPTH,
    parameter int PKT_LEN   = 16,
    localparam int LEVEL_W  = $clog2(BUF_DEPTH) + 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic               fifo_empty,
    output logic               fifo_rd_en,
    input  logic [WIDTH-1:0]   fifo_dout,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [WIDTH-1:0]   m_data,
    output logic               m_last,
    output logic [LEVEL_W-1:0] level
);

    localparam int                BEAT_W    = ptr_w(PKT_LEN);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_LEN - 1);

    logic               inflight;
    logic [LEVEL_W-1:0] occ;
    logic [LEVEL_W:0]   committed;
    logic               pop;
    logic [BEAT_W-1:0]  beat_cnt;

    // Slots already spoken for: stored words plus the word returning next edge.
    // Only registered state feeds this, so m_ready never reaches fifo_rd_en.
    assign committed  = {1'b0, occ} + {{LEVEL_W{1'b0}}, inflight};
    assign fifo_rd_en = reset_n & enable & ~fifo_empty
                      & (committed < (LEVEL_W+1)'(BUF_DEPTH));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) inflight <= 1'b0;
        else          inflight <= fifo_rd_en;
    end

    fifo_prefetch_buf #(
        .WIDTH (WIDTH),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (inflight),
        .push_data (fifo_dout),
        .pop       (pop),
        .pop_data  (m_data),
        .occ       (occ)
    );

    assign m_valid = (occ != '0);
    assign pop     = m_valid & m_ready;
    assign level   = occ;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            beat_cnt <= '0;
        end else if (pop) begin
            beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + 1'b1;
        end
    end

    assign m_last = m_valid & (beat_cnt == LAST_BEAT);

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: a FIFO source model drives the read port, and a
// behavioural reference (expected-word queue plus occupancy/packet counts) is
// compared against the DUT outputs on every falling edge.
module tb_fifo_stream_reader;

    localparam int WIDTH     = 8;
    localparam int BUF_DEPTH = 4;
    localparam int PKT_LEN   = 16;
    localparam int LEVEL_W   = $clog2(BUF_DEPTH) + 1;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               enable = 1'b1;
    logic               fifo_empty = 1'b0;
    logic               fifo_rd_en;
    logic [WIDTH-1:0]   fifo_dout = '0;
    logic               m_valid;
    logic               m_ready = 1'b1;
    logic [WIDTH-1:0]   m_data;
    logic               m_last;
    logic [LEVEL_W-1:0] level;

    always #5 clk = ~clk;

    fifo_stream_reader #(
        .WIDTH     (WIDTH),
        .BUF_DEPTH (BUF_DEPTH),
        .PKT_LEN   (PKT_LEN)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .fifo_dout  (fifo_dout),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .level      (level)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Words the FIFO handed out, oldest first; stream must replay them exactly.
    logic [WIDTH-1:0] exp_q[$];
    int  occ_m  = 0;   // words stored and not yet consumed
    int  infl_m = 0;   // word returning from the FIFO next edge
    int  beat_m = 0;   // position of the head word inside its packet
    bit  exp_rd, exp_valid, exp_last;

    initial forever begin
        @(negedge clk);
        if (!reset_n) begin
            check("rst_rd_en",   32'(fifo_rd_en), 32'(0));
            check("rst_m_valid", 32'(m_valid),    32'(0));
            check("rst_m_last",  32'(m_last),     32'(0));
            check("rst_level",   32'(level),      32'(0));
            occ_m = 0; infl_m = 0; beat_m = 0;
            exp_q.delete();
        end else begin
            exp_rd    = enable && !fifo_empty && (occ_m + infl_m < BUF_DEPTH);
            exp_valid = (occ_m != 0);
            exp_last  = exp_valid && (beat_m == PKT_LEN - 1);
            check("rd_en",   32'(fifo_rd_en), 32'(exp_rd));
            check("m_valid", 32'(m_valid),    32'(exp_valid));
            check("m_last",  32'(m_last),     32'(exp_last));
            check("level",   32'(level),      32'(occ_m));
            if (exp_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL m_data: got %0h, want <no word outstanding>", m_data);
                end else begin
                    check("m_data", 32'(m_data), 32'(exp_q[0]));
                end
            end
            if (infl_m != 0) occ_m++;
            if (exp_valid && m_ready) begin
                occ_m--;
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                beat_m = (beat_m == PKT_LEN - 1) ? 0 : beat_m + 1;
            end
            infl_m = exp_rd ? 1 : 0;
        end
    end

    // ---------------- FIFO source and stimulus ----------------
    typedef struct {
        logic [WIDTH-1:0] data;
        bit               last;
        int               cyc;
    } beat_t;

    logic [WIDTH-1:0] src_q[$];
    beat_t            log_q[$];
    int  p_en = 100, p_rdy = 100, p_emp = 0;
    int  cyc = 0;
    int  fifo_reads = 0;
    bit  s_rd, s_valid, s_last, s_ready, s_empty;
    logic [WIDTH-1:0]   s_data;
    logic [LEVEL_W-1:0] s_level;
    int  s_cyc;

    // One clock: sample outputs at the falling edge, then act as the FIFO and
    // drive the next cycle's inputs just after the rising edge.
    task automatic tick();
        @(negedge clk);
        s_rd = fifo_rd_en; s_valid = m_valid; s_last = m_last; s_data = m_data;
        s_level = level; s_ready = m_ready; s_empty = fifo_empty; s_cyc = cyc;
        if (s_valid && s_ready) log_q.push_back('{s_data, s_last, s_cyc});
        @(posedge clk);
        #1;
        cyc++;
        if (s_rd && !s_empty && src_q.size() != 0) begin
            fifo_dout = src_q.pop_front();
            exp_q.push_back(fifo_dout);
            fifo_reads++;
        end else begin
            fifo_dout = WIDTH'($urandom);
        end
        enable     = ($urandom_range(0, 99) < p_en);
        m_ready    = ($urandom_range(0, 99) < p_rdy);
        fifo_empty = (src_q.size() == 0) || ($urandom_range(0, 99) < p_emp);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic run_until_beats(input int n, input int budget, input string name);
        int k = 0;
        while (log_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        check({name, "_beats"}, 32'(log_q.size()), 32'(n));
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int rd_cyc, v_cyc, reads0, k;
        logic [WIDTH-1:0] v_data;
        bit v_last;

        // 1: reset with a non-empty FIFO and enable high
        reset_n = 1'b0; enable = 1'b1; fifo_empty = 1'b0; m_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("t1_rd_en",   32'(fifo_rd_en), 32'(0));
        check("t1_m_valid", 32'(m_valid),    32'(0));
        check("t1_m_last",  32'(m_last),     32'(0));
        check("t1_level",   32'(level),      32'(0));
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // 2: a single word, latency from read request to m_valid
        src_q.push_back(8'hA5);
        fifo_empty = 1'b0;
        rd_cyc = -100; v_cyc = -1; v_data = '0; v_last = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (s_rd && rd_cyc < 0) rd_cyc = s_cyc;
            if (s_valid && v_cyc < 0) begin
                v_cyc = s_cyc; v_data = s_data; v_last = s_last;
            end
        end
        check("t2_latency", 32'(v_cyc - rd_cyc), 32'(2));
        check("t2_m_data",  32'(v_data),         32'(8'hA5));
        check("t2_m_last",  32'(v_last),         32'(0));
        check("t2_level",   32'(s_level),        32'(0));

        // 3: 32 words streaming, packets of 16
        do_reset();
        log_q.delete();
        for (int i = 0; i < 32; i++) src_q.push_back(WIDTH'(i));
        fifo_empty = 1'b0;
        run_until_beats(32, 100, "t3");
        for (int i = 0; i < 32 && i < log_q.size(); i++) begin
            check($sformatf("t3_data_%0d", i), 32'(log_q[i].data), 32'(i));
            check($sformatf("t3_last_%0d", i), 32'(log_q[i].last), 32'((i == 15) || (i == 31)));
        end
        if (log_q.size() >= 32)
            check("t3_span", 32'(log_q[31].cyc - log_q[0].cyc), 32'(31));

        // 4: backpressure fills the buffer, then drains in order
        log_q.delete();
        reads0 = fifo_reads;
        p_rdy = 0; m_ready = 1'b0;
        for (int i = 0; i < 20; i++) src_q.push_back(WIDTH'(100 + i));
        fifo_empty = 1'b0;
        repeat (8) tick();
        check("t4_level",   32'(s_level),             32'(4));
        check("t4_rd_en",   32'(s_rd),                32'(0));
        check("t4_m_valid", 32'(s_valid),             32'(1));
        check("t4_reads",   32'(fifo_reads - reads0), 32'(4));
        p_rdy = 100; m_ready = 1'b1;
        run_until_beats(20, 100, "t4");
        for (int i = 0; i < 20 && i < log_q.size(); i++)
            check($sformatf("t4_data_%0d", i), 32'(log_q[i].data), 32'(100 + i));

        // 5: drop enable with a read in flight
        log_q.delete();
        reads0 = fifo_reads;
        for (int i = 0; i < 10; i++) src_q.push_back(WIDTH'(200 + i));
        fifo_empty = 1'b0;
        k = 0;
        do begin
            tick();
            k++;
        end while (!s_rd && k < 10);
        check("t5_read_seen", 32'(s_rd), 32'(1));
        p_en = 0; enable = 1'b0;
        tick();
        check("t5_no_rd", 32'(s_rd), 32'(0));
        repeat (6) tick();
        check("t5_level",   32'(s_level), 32'(0));
        check("t5_m_valid", 32'(s_valid), 32'(0));
        check("t5_drained", 32'(log_q.size()), 32'(fifo_reads - reads0));
        src_q.delete();
        p_en = 100; enable = 1'b1;

        // 6: reset after beat 5 of a packet, then a fresh 16-beat packet
        do_reset();
        log_q.delete();
        for (int i = 0; i < 12; i++) src_q.push_back(WIDTH'(30 + i));
        fifo_empty = 1'b0;
        run_until_beats(6, 50, "t6a");
        reset_n = 1'b0;
        tick();
        check("t6_m_valid", 32'(s_valid), 32'(0));
        check("t6_level",   32'(s_level), 32'(0));
        check("t6_rd_en",   32'(s_rd),    32'(0));
        src_q.delete();
        reset_n = 1'b1;
        log_q.delete();
        for (int i = 0; i < 16; i++) src_q.push_back(WIDTH'(50 + i));
        fifo_empty = 1'b0;
        run_until_beats(16, 60, "t6b");
        for (int i = 0; i < 16 && i < log_q.size(); i++) begin
            check($sformatf("t6_data_%0d", i), 32'(log_q[i].data), 32'(50 + i));
            check($sformatf("t6_last_%0d", i), 32'(log_q[i].last), 32'(i == 15));
        end

        // Random: gaps in supply, enable and ready; the compare process checks every cycle
        do_reset();
        log_q.delete();
        reads0 = fifo_reads;
        for (int i = 0; i < 400; i++) src_q.push_back(WIDTH'($urandom));
        p_en = 85; p_rdy = 70; p_emp = 25;
        repeat (1500) tick();
        p_en = 100; p_rdy = 100; p_emp = 0;
        k = 0;
        while ((src_q.size() != 0 || s_level != 0 || s_rd) && k < 600) begin
            tick();
            k++;
        end
        repeat (4) tick();
        check("rand_src_empty", 32'(src_q.size()), 32'(0));
        check("rand_level",     32'(s_level),      32'(0));
        check("rand_all_out",   32'(log_q.size()), 32'(fifo_reads - reads0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
